program_counter: RTL and testbench



---
 rtl/program_counter.sv | 77 +++++++
 tb/tb_program_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// rtl/program_counter.sv - RV32 instruction-fetch program counter
// Optional macro PC_ALIGN_CHECK_EN: word-aligns jump targets and adds misalign_o
module program_counter #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          INC_STEP   = 4,
   parameter int          HOLD_W     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              jump_flag_i,
   input  logic [31:0]       jump_addr_i,
   input  logic [HOLD_W-1:0] hold_flag_i,
   input  logic              jtag_reset_i,
`ifdef PC_ALIGN_CHECK_EN
   output logic              misalign_o,
`endif
   output logic [31:0]       pc_o
);

   localparam logic [31:0] INC_VAL = INC_STEP[31:0];

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_jump_target;
   logic        w_misalign;
   logic        w_misalign_next;

`ifdef PC_ALIGN_CHECK_EN
   assign w_jump_target = {jump_addr_i[31:2], 2'b00};
   assign w_misalign    = |jump_addr_i[1:0];
`else
   assign w_jump_target = jump_addr_i;
   assign w_misalign    = 1'b0;
`endif

   // Any non-zero hold code (wait, flush, reserved) freezes fetch unless a jump is present
   always_comb begin
      w_pc_next       = r_pc + INC_VAL;
      w_misalign_next = 1'b0;
      if (jtag_reset_i) begin
         w_pc_next = RESET_ADDR;
      end else if (jump_flag_i) begin
         w_pc_next       = w_jump_target;
         w_misalign_next = w_misalign;
      end else if (hold_flag_i != '0) begin
         w_pc_next = r_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_ADDR;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign pc_o = r_pc;

`ifdef PC_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_misalign_next;
      end
   end

   assign misalign_o = r_misalign;
`else
   logic w_unused;
   assign w_unused = w_misalign_next;
`endif

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - randomized self-checking bench for program_counter
// Honors PC_ALIGN_CHECK_EN when the design is built with it
module tb_program_counter;

   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = 32'h0;
   logic [2:0]  hold_flag_i = 3'b000;
   logic        jtag_reset_i = 1'b0;
   logic [31:0] pc_o;
`ifdef PC_ALIGN_CHECK_EN
   logic        misalign_o;
`endif

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] m_pc;
   logic        m_mis;

   always #5 clk = ~clk;

   program_counter #(.RESET_ADDR(RESET_ADDR), .INC_STEP(4), .HOLD_W(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .hold_flag_i  (hold_flag_i),
      .jtag_reset_i (jtag_reset_i),
`ifdef PC_ALIGN_CHECK_EN
      .misalign_o   (misalign_o),
`endif
      .pc_o         (pc_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic step(input logic rn, input logic jr, input logic jf,
                       input logic [31:0] ja, input logic [2:0] hf, input string tag);
      rst_n        = rn;
      jtag_reset_i = jr;
      jump_flag_i  = jf;
      jump_addr_i  = ja;
      hold_flag_i  = hf;
      @(posedge clk);
      m_mis = 1'b0;
      if (!rn || jr) begin
         m_pc = RESET_ADDR;
      end else if (jf) begin
`ifdef PC_ALIGN_CHECK_EN
         m_pc  = ja - (ja % 4);
         m_mis = (ja % 4) != 0;
`else
         m_pc  = ja;
`endif
      end else if (hf == 3'd0) begin
         m_pc = m_pc + 32'd4;
      end
      #1;
      check(tag, pc_o, m_pc);
`ifdef PC_ALIGN_CHECK_EN
      check({tag, "_mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
`endif
   endtask

   initial begin
      m_pc  = RESET_ADDR;
      m_mis = 1'b0;

      step(0, 0, 0, 0, 0, "reset0");
      step(0, 0, 0, 0, 0, "reset1");
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, "count");
      check("after10", pc_o, 32'h28);

      step(1, 0, 0, 0, 3'b001, "wait0");
      step(1, 0, 0, 0, 3'b001, "wait1");
      check("stall_hold", pc_o, 32'h28);
      step(1, 0, 0, 0, 0, "resume0");
      step(1, 0, 0, 0, 0, "resume1");
      check("resume_val", pc_o, 32'h30);

      step(1, 0, 1, 32'h0200_0000, 3'b010, "flush_jump");
      check("flush_jump_val", pc_o, 32'h0200_0000);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, "post_jump");
      step(1, 0, 0, 0, 3'b010, "flush_only");
      step(1, 0, 0, 0, 3'b111, "reserved");
      check("frozen_val", pc_o, 32'h0200_0010);

      step(1, 1, 1, 32'h0000_1000, 0, "jtag_jump");
      check("jtag_val", pc_o, RESET_ADDR);
      step(1, 0, 0, 0, 0, "jtag_rel0");
      step(1, 0, 0, 0, 0, "jtag_rel1");

      step(1, 0, 1, 32'hFFFF_FFFC, 0, "wrap_jump");
      step(1, 0, 0, 0, 0, "wrap_inc");
      check("wrap_val", pc_o, 32'h0);

      step(1, 0, 0, 0, 0, "pre_rst");
      step(0, 0, 1, 32'h0000_5000, 3'b010, "rst_jump");
      check("rst_jump_val", pc_o, RESET_ADDR);

      step(1, 0, 1, 32'h0000_1002, 0, "misjump");
      step(1, 0, 0, 0, 0, "misjump_next");

      for (int i = 0; i < 400; i++) begin
         logic        rn, jr, jf;
         logic [31:0] ja;
         logic [2:0]  hf;
         rn = ($urandom_range(0, 31) != 0);
         jr = ($urandom_range(0, 15) == 0);
         jf = ($urandom_range(0, 7) == 0);
         ja = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
         hf = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
         step(rn, jr, jf, ja, hf, "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
